// File: rtl/mux_arb_pkg.sv
// Shared types and default sizing for the round-robin mux arbiter slice.
package mux_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam int NUM_REQ_DEF = 4;
    localparam int DATA_W_DEF  = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of eligible at or after ptr, wrapping.
module rr_pick
    import mux_arb_pkg::*;
#(
    parameter int N     = NUM_REQ_DEF,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     eligible,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] winner
);

    localparam logic [SEL_W:0] N_EXT = (SEL_W + 1)'(N);

    logic [N-1:0]     rot_s;
    logic [SEL_W-1:0] off_s;
    logic [SEL_W:0]   sum_s;

    // Rotate so ptr lands at bit 0, priority-encode, then map the offset back to an index
    always_comb begin
        rot_s  = N'({eligible, eligible} >> ptr);
        found  = |eligible;
        off_s  = {SEL_W{1'b0}};
        for (int k = N - 1; k >= 0; k--) begin
            off_s = rot_s[k] ? SEL_W'(k) : off_s;
        end
        sum_s = {1'b0, ptr} + {1'b0, off_s};
        if (sum_s >= N_EXT) begin
            winner = SEL_W'(sum_s - N_EXT);
        end else begin
            winner = sum_s[SEL_W-1:0];
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter feeding a registered mux output stage.
// Optional burst lock is enabled by defining MUX_ARB_LOCK_EN.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int SEL_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
`ifdef MUX_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]        req_lock,
`endif
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [SEL_W-1:0]          out_sel,
    input  logic                      out_ready
);

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_REQ - 1);

    arb_state_e       state_r;
    logic [SEL_W-1:0] rr_ptr_r;
    logic [NUM_REQ-1:0] eligible_s;
    logic             found_s;
    logic [SEL_W-1:0] winner_s;
    logic             can_accept_s;
    logic             grant_s;
    logic [SEL_W-1:0] next_ptr_s;

`ifdef MUX_ARB_LOCK_EN
    logic             lock_flag_r;
    logic [SEL_W-1:0] lock_idx_r;

    // While a burst is locked only the lock owner may compete
    always_comb begin
        if (lock_flag_r) begin
            eligible_s = req_valid & ({{(NUM_REQ-1){1'b0}}, 1'b1} << lock_idx_r);
        end else begin
            eligible_s = req_valid;
        end
    end
`else
    // Pure round-robin: every valid requester competes
    always_comb begin
        eligible_s = req_valid;
    end
`endif

    rr_pick #(
        .N     (NUM_REQ),
        .SEL_W (SEL_W)
    ) u_rr_pick (
        .eligible (eligible_s),
        .ptr      (rr_ptr_r),
        .found    (found_s),
        .winner   (winner_s)
    );

    // Grant decision; rst_n gates ready so nothing is offered while reset is held
    always_comb begin
        can_accept_s = (state_r == IDLE) || out_ready;
        grant_s      = rst_n && can_accept_s && found_s;
        req_ready    = {NUM_REQ{1'b0}};
        if (grant_s) begin
            req_ready[winner_s] = 1'b1;
        end else begin
            req_ready = {NUM_REQ{1'b0}};
        end
        if (winner_s == LAST_IDX) begin
            next_ptr_s = {SEL_W{1'b0}};
        end else begin
            next_ptr_s = winner_s + SEL_W'(1);
        end
    end

    // Output register, FSM and round-robin pointer; a grant overrides a drain in the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            out_valid <= 1'b0;
            out_data  <= {DATA_W{1'b0}};
            out_sel   <= {SEL_W{1'b0}};
            rr_ptr_r  <= {SEL_W{1'b0}};
        end else if (grant_s) begin
            state_r   <= BUSY;
            out_valid <= 1'b1;
            out_data  <= req_data[winner_s*DATA_W +: DATA_W];
            out_sel   <= winner_s;
            rr_ptr_r  <= next_ptr_s;
        end else begin
            case (state_r)
                IDLE: begin
                    out_valid <= 1'b0;
                end
                BUSY: begin
                    if (out_ready) begin
                        state_r   <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef MUX_ARB_LOCK_EN
    // Lock tracks the req_lock of the last accepted transfer; release resumes after lock_idx
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_flag_r <= 1'b0;
            lock_idx_r  <= {SEL_W{1'b0}};
        end else if (grant_s) begin
            lock_flag_r <= req_lock[winner_s];
            lock_idx_r  <= winner_s;
        end
    end
`endif

endmodule
